// File: rtl/alu_control_sequencer.sv
// Purpose: fetch/decode/execute sequencer that drives an external ALU from a sync-read program ROM
//          and keeps a 4x8-bit register file updated with the ALU results.
// Latency: 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK); HALT is reached 2 cycles after its fetch.
// Backpressure: none; start is accepted only in IDLE or HALT and is ignored while busy.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   1-cycle pulse, (re)starts execution at pc=0
//   pc / instr              ROM address out, ROM data in (one cycle later)
//   alu_opcode/alu_a/alu_b/alu_load_number   registered ALU drive
//   alu_out / alu_flag      ALU result and flags, sampled in WRITEBACK
//   flags, busy, halted     registered status
//   dbg_sel / dbg_data      combinational register file read port
module alu_control_sequencer #(
  parameter int         PC_W    = 8,
  parameter logic [3:0] IDLE_OP = 4'hF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [15:0]     instr,
  output logic [3:0]      alu_opcode,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [7:0]      alu_load_number,
  input  logic [7:0]      alu_out,
  input  logic [3:0]      alu_flag,
  output logic [3:0]      flags,
  output logic            busy,
  output logic            halted,
  input  logic [1:0]      dbg_sel,
  output logic [7:0]      dbg_data
);

  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [3:0] LOAD_OP = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t     state;
  // Only the fields used after DECODE are kept from the instruction register;
  // operands and immediate are captured straight into the ALU drive registers.
  logic [3:0] ir_op;
  logic [1:0] ir_rd;
  logic [7:0] regs [4];

  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      pc              <= '0;
      ir_op           <= '0;
      ir_rd           <= '0;
      flags           <= '0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      alu_opcode      <= IDLE_OP;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_load_number <= '0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            busy  <= 1'b1;
          end
        end

        // pc is already on the ROM address bus; data arrives next cycle.
        S_FETCH: begin
          state <= S_DECODE;
        end

        S_DECODE: begin
          ir_op           <= instr[15:12];
          ir_rd           <= instr[11:10];
          alu_a           <= regs[instr[11:10]];
          alu_b           <= regs[instr[9:8]];
          alu_load_number <= instr[7:0];
          if (instr[15:12] == HALT_OP) begin
            state      <= S_HALT;
            busy       <= 1'b0;
            halted     <= 1'b1;
            alu_opcode <= IDLE_OP;
          end else begin
            state <= S_EXECUTE;
          end
        end

        // Operands were settled during the previous cycle, so the opcode
        // edge always lands on stable operands.
        S_EXECUTE: begin
          alu_opcode <= ir_op;
          state      <= S_WRITEBACK;
        end

        S_WRITEBACK: begin
          case (ir_op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
              regs[ir_rd] <= alu_out;
              flags       <= alu_flag;
            end
            LOAD_OP: begin
              regs[ir_rd] <= alu_out;
            end
            default: begin
              // 0111-1101 are no-ops: nothing written.
            end
          endcase
          // Dropping back to IDLE_OP gives back-to-back identical ops a fresh edge.
          alu_opcode <= IDLE_OP;
          pc         <= pc + PC_W'(1);
          state      <= S_FETCH;
        end

        // Registers and flags survive a restart; only pc is rewound.
        S_HALT: begin
          if (start) begin
            state  <= S_FETCH;
            pc     <= '0;
            halted <= 1'b0;
            busy   <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Purpose: directed bench for alu_control_sequencer with a sync ROM, a behavioural ALU and an operand scoreboard.
// Latency: ALU is combinational; ROM returns data one cycle after the address.
// Backpressure: none; the bench only pulses start and watches the ALU bus.
module tb_alu_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  pc;
  logic [15:0] instr = 16'h0;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_load_number;
  logic [7:0]  alu_out;
  logic [3:0]  alu_flag;
  logic [3:0]  flags;
  logic        busy;
  logic        halted;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_control_sequencer #(.PC_W(8), .IDLE_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .instr(instr),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_load_number(alu_load_number), .alu_out(alu_out), .alu_flag(alu_flag),
    .flags(flags), .busy(busy), .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Program ROM with one cycle read latency.
  logic [15:0] rom [256];
  always @(posedge clk) instr <= rom[pc];

  // Behavioural ALU: flags are one-hot with carry > negative > zero.
  // Unknown ops return a poison value so a stray writeback is visible.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] imm);
    logic [8:0] s;
    logic [7:0] r;
    s = 9'd0;
    case (op)
      4'h0: s = {1'b0, a} + {1'b0, b};
      4'h1: s = {1'b0, a - b};
      4'h2: s = {1'b0, a & b};
      4'h3: s = {1'b0, a | b};
      4'h4: s = {1'b0, a ^ b};
      4'h5: s = {1'b0, a << 1};
      4'h6: s = {1'b0, a >> 1};
      4'hE: s = {1'b0, imm};
      default: return {4'b0010, 8'h5A};
    endcase
    r = s[7:0];
    if (s[8])          return {4'b1000, r};
    else if (r[7])     return {4'b0100, r};
    else if (r == 0)   return {4'b0010, r};
    else               return {4'b0000, r};
  endfunction

  assign {alu_flag, alu_out} = alu_fn(alu_opcode, alu_a, alu_b, alu_load_number);

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_r [4];
  logic [7:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level model: queues the ALU bus traffic each instruction should produce.
  task automatic model_run(input int max_instr);
    logic [15:0] w;
    logic [11:0] res;
    int n;
    n = 0;
    m_pc = 8'd0;
    while (n < max_instr) begin
      w = rom[m_pc];
      if (w[15:12] == 4'hF) break;
      sb.push_back('{op: w[15:12], a: m_r[w[11:10]], b: m_r[w[9:8]], imm: w[7:0]});
      res = alu_fn(w[15:12], m_r[w[11:10]], m_r[w[9:8]], w[7:0]);
      if (w[15:12] <= 4'h6 || w[15:12] == 4'hE) m_r[w[11:10]] = res[7:0];
      m_pc = m_pc + 8'd1;
      n++;
    end
  endtask

  // Scoreboard consumer: every non-idle opcode is one executing instruction.
  logic [3:0] prev_op = 4'hF;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && alu_opcode != 4'hF) begin
      chk("opcode idle before op", {28'd0, prev_op}, 32'hF);
      if (sb.size() == 0) begin
        chk("scoreboard underflow", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb opcode", {28'd0, alu_opcode}, {28'd0, e.op});
        chk("sb alu_a", {24'd0, alu_a}, {24'd0, e.a});
        chk("sb alu_b", {24'd0, alu_b}, {24'd0, e.b});
        chk("sb imm", {24'd0, alu_load_number}, {24'd0, e.imm});
      end
    end
    prev_op = rst_n ? alu_opcode : 4'hF;
  end

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_pc(input string tag, input logic [7:0] target, input int budget);
    int n;
    n = 0;
    while (pc !== target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " pc reached"}, {24'd0, pc}, {24'd0, target});
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s R%0d", tag, i), {24'd0, dbg_data}, {24'd0, e[i]});
    end
  endtask

  task automatic run_prog(input string tag);
    model_run(64);
    pulse_start();
    wait_halted(tag, 60);
    chk({tag, " sb drained"}, sb.size(), 32'd0);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " opcode idle"}, {28'd0, alu_opcode}, 32'hF);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
    rom_clear();

    // Reset state
    #12;
    chk("rst pc", {24'd0, pc}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst halted", {31'd0, halted}, 32'd0);
    chk("rst opcode", {28'd0, alu_opcode}, 32'hF);
    chk("rst alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst flags", {28'd0, flags}, 32'd0);
    check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // T1: R0=5, R1=3 (rd is bits[11:10], so R1 load is E403), R0+=R1, halt
    rom_clear();
    rom[0] = 16'hE105; rom[1] = 16'hE403; rom[2] = 16'h0100;
    run_prog("t1");
    check_regs("t1", 8'h08, 8'h03, 8'h00, 8'h00);
    chk("t1 flags", {28'd0, flags}, 32'h0);
    chk("t1 pc", {24'd0, pc}, 32'd3);

    // T2: carry on FF+01, then restart from HALT keeps registers: SUB R1,R1 -> zero
    rom_clear();
    rom[0] = 16'hE0FF; rom[1] = 16'hE401; rom[2] = 16'h0100;
    run_prog("t2a");
    check_regs("t2a", 8'h00, 8'h01, 8'h00, 8'h00);
    chk("t2a flags", {28'd0, flags}, 32'h8);
    rom_clear();
    rom[0] = 16'h1500;
    run_prog("t2b");
    check_regs("t2b", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t2b flags", {28'd0, flags}, 32'h2);
    chk("t2b pc", {24'd0, pc}, 32'd1);

    // T3: SUB 3-7 -> FC negative; later load leaves flags alone
    rom_clear();
    rom[0] = 16'hE803; rom[1] = 16'hEC07; rom[2] = 16'h1B00;
    run_prog("t3a");
    check_regs("t3a", 8'h00, 8'h00, 8'hFC, 8'h07);
    chk("t3a flags", {28'd0, flags}, 32'h4);
    rom_clear();
    rom[0] = 16'hE81E;
    run_prog("t3b");
    check_regs("t3b", 8'h00, 8'h00, 8'h1E, 8'h07);
    chk("t3b flags", {28'd0, flags}, 32'h4);

    // T4: two identical ADDs back to back, then a NOP (op A) targeting R0
    rom_clear();
    rom[0] = 16'hE001; rom[1] = 16'hE402; rom[2] = 16'h0100; rom[3] = 16'h0100;
    rom[4] = 16'hA123;
    run_prog("t4");
    check_regs("t4", 8'h05, 8'h02, 8'h1E, 8'h07);
    chk("t4 flags", {28'd0, flags}, 32'h0);
    chk("t4 pc", {24'd0, pc}, 32'd5);

    // T5: reset lands in EXECUTE of the ADD at pc=2
    rom_clear();
    rom[0] = 16'hE105; rom[1] = 16'hE403; rom[2] = 16'h0100;
    model_run(64);
    pulse_start();
    repeat (10) @(posedge clk);
    #2;
    chk("t5 exec pc", {24'd0, pc}, 32'd2);
    chk("t5 exec alu_a", {24'd0, alu_a}, 32'h05);
    chk("t5 exec alu_b", {24'd0, alu_b}, 32'h03);
    chk("t5 exec opcode", {28'd0, alu_opcode}, 32'hF);
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("t5 rst pc", {24'd0, pc}, 32'd0);
    chk("t5 rst busy", {31'd0, busy}, 32'd0);
    chk("t5 rst alu_a", {24'd0, alu_a}, 32'd0);
    chk("t5 rst imm", {24'd0, alu_load_number}, 32'd0);
    chk("t5 rst opcode", {28'd0, alu_opcode}, 32'hF);
    check_regs("t5 rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t5 add never issued", sb.size(), 32'd1);
    sb.delete();
    for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
    @(posedge clk); #1;
    chk("t5 start under reset", {31'd0, busy}, 32'd0);
    @(negedge clk) start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5 still idle", {31'd0, busy}, 32'd0);
    run_prog("t5 rerun");
    check_regs("t5 rerun", 8'h08, 8'h03, 8'h00, 8'h00);

    // T6: 256+ NOPs, pc wraps; start while busy ignored
    for (int i = 0; i < 256; i++) rom[i] = 16'h7000;
    model_run(258);
    pulse_start();
    wait_pc("t6 early", 8'd10, 60);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("t6 start ignored pc", {24'd0, pc}, 32'd12);
    chk("t6 busy", {31'd0, busy}, 32'd1);
    wait_pc("t6 top", 8'hFF, 1100);
    wait_pc("t6 wrap", 8'h00, 8);
    wait_pc("t6 after wrap", 8'h02, 12);
    chk("t6 sb drained", sb.size(), 32'd0);
    chk("t6 busy after wrap", {31'd0, busy}, 32'd1);
    chk("t6 halted", {31'd0, halted}, 32'd0);
    check_regs("t6", 8'h08, 8'h03, 8'h00, 8'h00);
    chk("t6 flags", {28'd0, flags}, 32'h0);

    rst_n = 1'b0;
    #20;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
